// File: rtl/decrypt_req_join.sv
// Joins the DECRYPT_REQ buffer stream with its four per-packet struct side channels and emits
// one registered AXIS stream whose every beat carries the packet's concatenated metadata.
module decrypt_req_join #(
  parameter int BUF_DATA_WIDTH = 512,
  parameter int BUF_KEEP_WIDTH = 64,
  parameter int S1_WIDTH       = 272,
  parameter int S2_WIDTH       = 184,
  parameter int S3_WIDTH       = 112,
  parameter int S4_WIDTH       = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [BUF_DATA_WIDTH-1:0]                      s_buf_tdata,
  input  logic [BUF_KEEP_WIDTH-1:0]                      s_buf_tkeep,
  input  logic                                           s_buf_tlast,
  input  logic                                           s_buf_tvalid,
  output logic                                           s_buf_tready,
  input  logic [S1_WIDTH-1:0]                            s_st1_tdata,
  input  logic                                           s_st1_tvalid,
  output logic                                           s_st1_tready,
  input  logic [S2_WIDTH-1:0]                            s_st2_tdata,
  input  logic                                           s_st2_tvalid,
  output logic                                           s_st2_tready,
  input  logic [S3_WIDTH-1:0]                            s_st3_tdata,
  input  logic                                           s_st3_tvalid,
  output logic                                           s_st3_tready,
  input  logic [S4_WIDTH-1:0]                            s_st4_tdata,
  input  logic                                           s_st4_tvalid,
  output logic                                           s_st4_tready,
  output logic [BUF_DATA_WIDTH-1:0]                      m_tdata,
  output logic [BUF_KEEP_WIDTH-1:0]                      m_tkeep,
  output logic                                           m_tlast,
  output logic                                           m_tfirst,
  output logic [S4_WIDTH+S3_WIDTH+S2_WIDTH+S1_WIDTH-1:0] m_meta,
  output logic                                           m_tvalid,
  input  logic                                           m_tready,
  output logic [CNT_WIDTH-1:0]                           pkt_count
);

  localparam int META_WIDTH = S4_WIDTH + S3_WIDTH + S2_WIDTH + S1_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {COLLECT, STREAM} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cap_q, cap_d;
  logic [S1_WIDTH-1:0]       reg1_q, reg1_d;
  logic [S2_WIDTH-1:0]       reg2_q, reg2_d;
  logic [S3_WIDTH-1:0]       reg3_q, reg3_d;
  logic [S4_WIDTH-1:0]       reg4_q, reg4_d;
  logic                      first_q, first_d;
  logic [BUF_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [BUF_KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic                      m_tlast_q, m_tlast_d;
  logic                      m_tfirst_q, m_tfirst_d;
  logic [META_WIDTH-1:0]     m_meta_q, m_meta_d;
  logic                      m_tvalid_q, m_tvalid_d;
  logic [CNT_WIDTH-1:0]      pkt_count_q, pkt_count_d;

  logic [3:0] st_vld, st_rdy, st_hs;
  logic       buf_hs;

  // Readies are gated by reset so nothing is accepted while the block is held in reset.
  assign st_vld = {s_st4_tvalid, s_st3_tvalid, s_st2_tvalid, s_st1_tvalid};
  assign st_rdy = (rst && state_q == COLLECT) ? ~cap_q : 4'b0000;
  assign st_hs  = st_vld & st_rdy;

  assign s_st1_tready = st_rdy[0];
  assign s_st2_tready = st_rdy[1];
  assign s_st3_tready = st_rdy[2];
  assign s_st4_tready = st_rdy[3];

  assign s_buf_tready = rst && (state_q == STREAM) && (!m_tvalid_q || m_tready);
  assign buf_hs       = s_buf_tvalid && s_buf_tready;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q | st_hs;
    reg1_d      = st_hs[0] ? s_st1_tdata : reg1_q;
    reg2_d      = st_hs[1] ? s_st2_tdata : reg2_q;
    reg3_d      = st_hs[2] ? s_st3_tdata : reg3_q;
    reg4_d      = st_hs[3] ? s_st4_tdata : reg4_q;
    first_d     = first_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tlast_d   = m_tlast_q;
    m_tfirst_d  = m_tfirst_q;
    m_meta_d    = m_meta_q;
    m_tvalid_d  = m_tvalid_q;
    pkt_count_d = pkt_count_q;

    // Move on as soon as the last missing struct lands, so the buffer opens the next cycle.
    if (state_q == COLLECT && (&cap_d))
      state_d = STREAM;

    if (buf_hs) begin
      m_tdata_d  = s_buf_tdata;
      m_tkeep_d  = s_buf_tkeep;
      m_tlast_d  = s_buf_tlast;
      m_tfirst_d = first_q;
      m_meta_d   = {reg4_q, reg3_q, reg2_q, reg1_q};
      m_tvalid_d = 1'b1;
      first_d    = s_buf_tlast;
      if (s_buf_tlast) begin
        // Meta for this beat is latched in the output register, so the struct regs may refill.
        cap_d       = 4'b0000;
        state_d     = COLLECT;
        pkt_count_d = pkt_count_q + CNT_ONE;
      end
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      cap_q       <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      reg4_q      <= '0;
      first_q     <= 1'b1;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tfirst_q  <= 1'b0;
      m_meta_q    <= '0;
      m_tvalid_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      reg3_q      <= reg3_d;
      reg4_q      <= reg4_d;
      first_q     <= first_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tlast_q   <= m_tlast_d;
      m_tfirst_q  <= m_tfirst_d;
      m_meta_q    <= m_meta_d;
      m_tvalid_q  <= m_tvalid_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign m_tdata   = m_tdata_q;
  assign m_tkeep   = m_tkeep_q;
  assign m_tlast   = m_tlast_q;
  assign m_tfirst  = m_tfirst_q;
  assign m_meta    = m_meta_q;
  assign m_tvalid  = m_tvalid_q;
  assign pkt_count = pkt_count_q;

endmodule
